// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field layout, fetch FSM states and the default reset PC.
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam int OPC_MSB = 31;
    localparam int OPC_W   = 6;
    localparam int REG_W   = 5;
    localparam int RS_LSB  = 21;
    localparam int RT_LSB  = 16;
    localparam int RD_LSB  = 11;
    localparam int FUNCT_W = 6;
    localparam int IMM_W   = 16;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_REQ = 2'd0,
        WAIT_RSP  = 2'd1,
        HOLD      = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/ir_field_split.sv
// Combinational slicer from a MIPS instruction word into its decode fields.
module ir_field_split
    import cpu_pkg::*;
(
    input  logic [INSTR_W-1:0] ir,
    output logic [OPC_W-1:0]   opcode,
    output logic [REG_W-1:0]   rs,
    output logic [REG_W-1:0]   rt,
    output logic [REG_W-1:0]   rd,
    output logic [FUNCT_W-1:0] funct,
    output logic [IMM_W-1:0]   imm
);

    assign opcode = ir[OPC_MSB -: OPC_W];
    assign rs     = ir[RS_LSB +: REG_W];
    assign rt     = ir[RT_LSB +: REG_W];
    assign rd     = ir[RD_LSB +: REG_W];
    assign funct  = ir[FUNCT_W-1:0];
    assign imm    = ir[IMM_W-1:0];

endmodule

// File: rtl/instr_fetch_unit.sv
// Multicycle MIPS fetch stage: one outstanding imem read, IR latch, redirect with response squash.
// Optional performance counters are enabled with the IFU_PERF_CNT_EN macro.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    parameter int                PC_STEP  = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [ADDR_W-1:0]  dec_pc,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [OPC_W-1:0]   dec_opcode,
    output logic [REG_W-1:0]   dec_rs,
    output logic [REG_W-1:0]   dec_rt,
    output logic [REG_W-1:0]   dec_rd,
    output logic [FUNCT_W-1:0] dec_funct,
    output logic [IMM_W-1:0]   dec_imm
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_squash_cnt
`endif
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q;
    logic [ADDR_W-1:0]  dec_pc_q;
    logic               squash_q, squash_d;
    logic               ir_load;

    // Requests are masked while reset is asserted so every output reads 0 during reset.
    assign imem_req_valid = reset_n && (state_q == FETCH_REQ) && !redirect_valid;
    assign imem_req_addr  = pc_q;
    assign dec_valid      = (state_q == HOLD) && !redirect_valid;
    assign dec_pc         = dec_pc_q;
    assign dec_instr      = ir_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        squash_d = squash_q;
        ir_load  = 1'b0;
        if (redirect_valid) begin
            pc_d = redirect_pc;
            unique case (state_q)
                FETCH_REQ: state_d = FETCH_REQ;
                WAIT_RSP: begin
                    if (imem_rsp_valid) begin
                        state_d  = FETCH_REQ;
                        squash_d = 1'b0;
                    end else begin
                        squash_d = 1'b1;
                    end
                end
                HOLD:      state_d = FETCH_REQ;
                default:   state_d = FETCH_REQ;
            endcase
        end else begin
            unique case (state_q)
                FETCH_REQ: begin
                    if (imem_req_ready) state_d = WAIT_RSP;
                end
                WAIT_RSP: begin
                    if (imem_rsp_valid) begin
                        if (squash_q) begin
                            squash_d = 1'b0;
                            state_d  = FETCH_REQ;
                        end else begin
                            ir_load = 1'b1;
                            pc_d    = pc_q + ADDR_W'(PC_STEP);
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (dec_ready) state_d = FETCH_REQ;
                end
                default: state_d = FETCH_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= FETCH_REQ;
            pc_q     <= RESET_PC;
            squash_q <= 1'b0;
            ir_q     <= '0;
            dec_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            squash_q <= squash_d;
            if (ir_load) begin
                ir_q     <= imem_rsp_data;
                dec_pc_q <= pc_q;
            end
        end
    end

    ir_field_split u_split (
        .ir     (ir_q),
        .opcode (dec_opcode),
        .rs     (dec_rs),
        .rt     (dec_rt),
        .rd     (dec_rd),
        .funct  (dec_funct),
        .imm    (dec_imm)
    );

`ifdef IFU_PERF_CNT_EN
    logic fetch_evt;
    logic drop_evt;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    // A drop is either a squashed/redirected response or an instruction lost from HOLD.
    assign fetch_evt = dec_valid && dec_ready;
    assign drop_evt  = ((state_q == HOLD) && redirect_valid) ||
                       ((state_q == WAIT_RSP) && imem_rsp_valid && (redirect_valid || squash_q));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetch_cnt  <= '0;
            perf_squash_cnt <= '0;
        end else begin
            if (fetch_evt) perf_fetch_cnt  <= sat_inc(perf_fetch_cnt);
            if (drop_evt)  perf_squash_cnt <= sat_inc(perf_squash_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: transaction-level model, directed scenarios and random traffic.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid, dec_ready;
    logic [31:0] dec_pc, dec_instr;
    logic [5:0]  dec_opcode, dec_funct;
    logic [4:0]  dec_rs, dec_rt, dec_rd;
    logic [15:0] dec_imm;

    logic        w_reset_n;
    logic        w_req_valid, w_req_ready;
    logic [31:0] w_req_addr;
    logic        w_rsp_valid;
    logic [31:0] w_rsp_data;
    logic        w_dec_valid, w_dec_ready;
    logic [31:0] w_dec_pc, w_dec_instr;
    logic [5:0]  w_dec_opcode, w_dec_funct;
    logic [4:0]  w_dec_rs, w_dec_rt, w_dec_rd;
    logic [15:0] w_dec_imm;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_squash_cnt;
    logic [31:0] w_perf_fetch_cnt, w_perf_squash_cnt;
`endif

    instr_fetch_unit dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc), .dec_instr(dec_instr),
        .dec_opcode(dec_opcode), .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_rd(dec_rd),
        .dec_funct(dec_funct), .dec_imm(dec_imm)
`ifdef IFU_PERF_CNT_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_squash_cnt(perf_squash_cnt)
`endif
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .reset_n(w_reset_n),
        .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_req_addr(w_req_addr),
        .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .dec_valid(w_dec_valid), .dec_ready(w_dec_ready), .dec_pc(w_dec_pc), .dec_instr(w_dec_instr),
        .dec_opcode(w_dec_opcode), .dec_rs(w_dec_rs), .dec_rt(w_dec_rt), .dec_rd(w_dec_rd),
        .dec_funct(w_dec_funct), .dec_imm(w_dec_imm)
`ifdef IFU_PERF_CNT_EN
        , .perf_fetch_cnt(w_perf_fetch_cnt), .perf_squash_cnt(w_perf_squash_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Transaction-level model: what the fetch unit owes the world, not how it is encoded.
    logic [31:0] m_pc, m_req_addr, m_instr, m_ipc;
    bit          m_out, m_sq, m_have;
    int          m_delay, m_fetch, m_squash;
    int          rsp_lat;
    bit          lat_rand;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_FFFF;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_req_addr = 32'h0; m_instr = 32'h0; m_ipc = 32'h0;
        m_out = 0; m_sq = 0; m_have = 0; m_delay = 0; m_fetch = 0; m_squash = 0;
    endtask

    task automatic compare();
        logic [31:0] mi;
        mi = m_instr;
        chk("req_valid", imem_req_valid, !m_out && !m_have && !redirect_valid);
        chk("req_addr",  imem_req_addr,  m_pc);
        chk("dec_valid", dec_valid,      m_have && !redirect_valid);
        chk("dec_instr", dec_instr,      mi);
        chk("dec_pc",    dec_pc,         m_ipc);
        chk("dec_opcode", dec_opcode,    mi[31:26]);
        chk("dec_rs",    dec_rs,         mi[25:21]);
        chk("dec_rt",    dec_rt,         mi[20:16]);
        chk("dec_rd",    dec_rd,         mi[15:11]);
        chk("dec_funct", dec_funct,      mi[5:0]);
        chk("dec_imm",   dec_imm,        mi[15:0]);
`ifdef IFU_PERF_CNT_EN
        chk("perf_fetch",  perf_fetch_cnt,  m_fetch);
        chk("perf_squash", perf_squash_cnt, m_squash);
`endif
    endtask

    // One clock: drive inputs on the falling edge, check, then advance the model.
    task automatic cycle(input bit redir, input logic [31:0] rpc, input bit rdy, input bit drdy, input bit late);
        bit          rsp;
        logic [31:0] data;
        @(negedge clk);
        rsp  = m_out && (m_delay == 0);
        data = rsp ? mem_word(m_req_addr) : $urandom;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_req_ready = rdy;
        dec_ready      = drdy;
        imem_rsp_valid = rsp || late;
        imem_rsp_data  = data;
        #1;
        compare();
        if (redir) begin
            if (m_have) begin
                m_have = 0; m_squash++;
            end else if (m_out) begin
                if (rsp) begin m_out = 0; m_sq = 0; m_squash++; end
                else begin m_sq = 1; m_delay--; end
            end
            m_pc = rpc;
        end else if (m_have) begin
            if (drdy) begin m_have = 0; m_fetch++; end
        end else if (m_out) begin
            if (rsp) begin
                m_out = 0;
                if (m_sq) begin
                    m_sq = 0; m_squash++;
                end else begin
                    m_have = 1; m_instr = data; m_ipc = m_pc; m_pc = m_pc + 32'd4;
                end
            end else begin
                m_delay--;
            end
        end else if (rdy) begin
            m_out = 1; m_req_addr = m_pc;
            m_delay = lat_rand ? int'($urandom_range(0, 3)) : rsp_lat;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        redirect_valid = 0; imem_req_ready = 0; dec_ready = 0; imem_rsp_valid = 0;
        #1;
        chk("rst_req_valid", imem_req_valid, 1'b0);
        chk("rst_dec_valid", dec_valid, 1'b0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_dec_instr", dec_instr, 32'h0);
        chk("rst_dec_pc", dec_pc, 32'h0);
`ifdef IFU_PERF_CNT_EN
        chk("rst_perf_fetch", perf_fetch_cnt, 32'h0);
        chk("rst_perf_squash", perf_squash_cnt, 32'h0);
`endif
        model_reset();
        @(posedge clk);
        #2 reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 0; w_reset_n = 0;
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
        redirect_valid = 0; redirect_pc = 0; dec_ready = 0;
        w_req_ready = 0; w_rsp_valid = 0; w_rsp_data = 0; w_dec_ready = 0;
        rsp_lat = 0; lat_rand = 0;
        model_reset();

        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_valid", imem_req_valid, 1'b0);
        chk("rst_dec_valid", dec_valid, 1'b0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_dec_instr", dec_instr, 32'h0);
        chk("rst_dec_imm", dec_imm, 16'h0);

        // PC wrap on the instance reset to the top word of the address space.
        @(negedge clk);
        w_reset_n = 1;
        #1;
        chk("wrap_req_valid", w_req_valid, 1'b1);
        chk("wrap_req_addr", w_req_addr, 32'hFFFF_FFFC);
        w_req_ready = 1;
        @(negedge clk);
        w_req_ready = 0; w_rsp_valid = 1; w_rsp_data = 32'h0123_4567;
        #1;
        chk("wrap_wait_req", w_req_valid, 1'b0);
        @(negedge clk);
        w_rsp_valid = 0;
        #1;
        chk("wrap_dec_valid", w_dec_valid, 1'b1);
        chk("wrap_dec_pc", w_dec_pc, 32'hFFFF_FFFC);
        chk("wrap_dec_instr", w_dec_instr, 32'h0123_4567);
        chk("wrap_pc", w_req_addr, 32'h0);
        w_dec_ready = 1;
        @(negedge clk);
        w_dec_ready = 0;
        #1;
        chk("wrap_next_valid", w_req_valid, 1'b1);
        chk("wrap_next_addr", w_req_addr, 32'h0);
        chk("wrap_next_dec", w_dec_valid, 1'b0);

        reset_n = 1;

        // Zero-wait fetch of 0x2008FFFF from address 0.
        cycle(0, 0, 1, 0, 0);
        chk("t1_req_addr", imem_req_addr, 32'h0);
        chk("t1_req_valid", imem_req_valid, 1'b1);
        cycle(0, 0, 1, 0, 0);
        chk("t1_wait_dec", dec_valid, 1'b0);
        cycle(0, 0, 1, 0, 0);
        chk("t1_dec_valid", dec_valid, 1'b1);
        chk("t1_opcode", dec_opcode, 6'h08);
        chk("t1_rt", dec_rt, 5'd8);
        chk("t1_imm", dec_imm, 16'hFFFF);
        chk("t1_dec_pc", dec_pc, 32'h0);
        chk("t1_pc_next", imem_req_addr, 32'h4);
        // Decode stalls for five cycles.
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 1, 0, 0);
            chk("stall_instr", dec_instr, 32'h2008_FFFF);
            chk("stall_no_req", imem_req_valid, 1'b0);
        end
        cycle(0, 0, 1, 1, 0);
        cycle(0, 0, 0, 0, 0);
        chk("t2_req_valid", imem_req_valid, 1'b1);
        chk("t2_req_addr", imem_req_addr, 32'h4);

        // Redirect while the response is pending.
        rsp_lat = 2;
        cycle(0, 0, 1, 0, 0);
        cycle(1, 32'h100, 1, 0, 0);
        chk("t3_dec_valid", dec_valid, 1'b0);
        repeat (3) cycle(0, 0, 0, 0, 0);
        chk("t3_req_valid", imem_req_valid, 1'b1);
        chk("t3_req_addr", imem_req_addr, 32'h100);
        chk("t3_dec_valid2", dec_valid, 1'b0);

        // Redirect coincident with the response.
        rsp_lat = 0;
        cycle(0, 0, 1, 0, 0);
        cycle(1, 32'h200, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        chk("t4_req_addr", imem_req_addr, 32'h200);
        chk("t4_dec_valid", dec_valid, 1'b0);

        // Redirect while an instruction is held.
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        chk("t5_held", dec_valid, 1'b1);
        chk("t5_held_pc", dec_pc, 32'h200);
        cycle(1, 32'h300, 0, 1, 0);
        chk("t5_masked", dec_valid, 1'b0);
        cycle(0, 0, 0, 0, 0);
        chk("t5_req_addr", imem_req_addr, 32'h300);
        chk("t5_req_valid", imem_req_valid, 1'b1);

        // Random traffic.
        lat_rand = 1;
        for (int i = 0; i < 1500; i++)
            cycle(($urandom % 10) == 0, $urandom & 32'hFFFF_FFFC,
                  ($urandom % 4) != 0, ($urandom % 3) != 0, 0);

        // Reset in the middle of a request, then a late response.
        lat_rand = 0;
        apply_reset();
        rsp_lat = 3;
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);
        apply_reset();
        cycle(0, 0, 0, 0, 1);
        chk("t6_req_addr", imem_req_addr, 32'h0);
        chk("t6_req_valid", imem_req_valid, 1'b1);
        cycle(0, 0, 0, 0, 0);
        chk("t6_dec_valid", dec_valid, 1'b0);
        rsp_lat = 1;
        for (int i = 0; i < 12; i++) cycle(0, 0, 1, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
